compound_dispatch: RTL and testbench

Parametrised successor of the two-section compound-message block. It accepts one compound message (mode, x, y) per handshake on a blocking input port and transforms it using an internal colour state. It then delivers the result on one of NCH blocking output channels, chosen round-robin, or on all channels at once in broadcast mode. It sits between a single message producer and NCH consumers in the compound-type datapath.

---
 rtl/compound_dispatch.sv | 97 +++++++++
 tb/tb_compound_dispatch.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/compound_dispatch.sv
// Compound-message dispatcher: receives (mode, x, y) in SEC_A, transforms it with the colour
// state, and delivers it in SEC_B round-robin to one of NCH consumers or broadcast to all.
module compound_dispatch #(
  parameter int XW  = 32,
  parameter int NCH = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           m_in_mode,
  input  logic [XW-1:0]  m_in_x,
  input  logic           m_in_y,
  input  logic           m_in_sync,
  output logic           m_in_notify,
  output logic           b_out_mode,
  output logic [XW-1:0]  b_out_x,
  output logic           b_out_y,
  input  logic [NCH-1:0] b_out_sync,
  output logic [NCH-1:0] b_out_notify,
  output logic [1:0]     color
);

  localparam int PW = $clog2((NCH > 1) ? NCH : 2);

  localparam logic [0:0] SEC_A = 1'b0;
  localparam logic [0:0] SEC_B = 1'b1;

  localparam logic [1:0] GREEN  = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] RED    = 2'd2;

  logic [0:0]     sec;
  logic [PW-1:0]  ptr;
  logic           bcast;
  logic           is_bcast;
  logic [NCH-1:0] unicast_mask;
  logic [NCH-1:0] pend_next;

  function automatic logic [XW-1:0] wrap_inc(input logic [XW-1:0] v);
    return v + XW'(1);
  endfunction

  function automatic logic [1:0] next_color(input logic [1:0] c);
    case (c)
      GREEN:   return YELLOW;
      YELLOW:  return RED;
      default: return GREEN;
    endcase
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(NCH - 1)) return '0;
    return p + PW'(1);
  endfunction

  always_comb begin
    unicast_mask      = '0;
    unicast_mask[ptr] = 1'b1;
  end

  // Broadcast is decided on the raw input y, before the colour-dependent flip.
  assign is_bcast  = m_in_mode & m_in_y;
  assign pend_next = b_out_notify & ~b_out_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec          <= SEC_A;
      color        <= GREEN;
      ptr          <= '0;
      bcast        <= 1'b0;
      m_in_notify  <= 1'b1;
      b_out_notify <= '0;
      b_out_mode   <= 1'b0;
      b_out_x      <= '0;
      b_out_y      <= 1'b0;
    end else if (sec == SEC_A) begin
      if (m_in_sync) begin
        sec          <= SEC_B;
        m_in_notify  <= 1'b0;
        b_out_mode   <= m_in_mode;
        b_out_x      <= m_in_mode ? wrap_inc(m_in_x) : m_in_x;
        b_out_y      <= m_in_y ^ (color == RED);
        bcast        <= is_bcast;
        b_out_notify <= is_bcast ? {NCH{1'b1}} : unicast_mask;
      end
    end else if (pend_next == '0) begin
      // Last pending channel taken: release the producer and move the state on.
      sec          <= SEC_A;
      m_in_notify  <= 1'b1;
      b_out_notify <= '0;
      color        <= next_color(color);
      if (!bcast) ptr <= next_ptr(ptr);
    end else begin
      b_out_notify <= pend_next;
    end
  end

endmodule

// File: tb/tb_compound_dispatch.sv
// Bench for compound_dispatch: NCH=2 instance driven from a vector table with a scoreboard,
// NCH=4 instance for the staggered broadcast sequence.
module tb_compound_dispatch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic       m_mode2, m_y2, m_sync2, m_notify2, o_mode2, o_y2;
  logic [7:0] m_x2, o_x2;
  logic [1:0] o_sync2, o_notify2, color2;

  logic       m_mode4, m_y4, m_sync4, m_notify4, o_mode4, o_y4;
  logic [7:0] m_x4, o_x4;
  logic [3:0] o_sync4, o_notify4;
  logic [1:0] color4;

  compound_dispatch #(.XW(8), .NCH(2)) dut2 (
    .clk(clk), .rst(rst),
    .m_in_mode(m_mode2), .m_in_x(m_x2), .m_in_y(m_y2), .m_in_sync(m_sync2),
    .m_in_notify(m_notify2),
    .b_out_mode(o_mode2), .b_out_x(o_x2), .b_out_y(o_y2),
    .b_out_sync(o_sync2), .b_out_notify(o_notify2), .color(color2)
  );

  compound_dispatch #(.XW(8), .NCH(4)) dut4 (
    .clk(clk), .rst(rst),
    .m_in_mode(m_mode4), .m_in_x(m_x4), .m_in_y(m_y4), .m_in_sync(m_sync4),
    .m_in_notify(m_notify4),
    .b_out_mode(o_mode4), .b_out_x(o_x4), .b_out_y(o_y4),
    .b_out_sync(o_sync4), .b_out_notify(o_notify4), .color(color4)
  );

  typedef struct {
    logic       md;
    logic [7:0] x;
    logic       y;
    logic [1:0] mask;
    logic [7:0] ex;
    logic       ey;
  } vec_t;

  typedef struct {
    logic [1:0] mask;
    logic       md;
    logic [7:0] x;
    logic       y;
  } exp_t;

  vec_t tbl[7];
  exp_t exp_q[$];
  int   acc_cyc;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, want);
    end
  endtask

  // Scoreboard: a new delivery on dut2 is the rising edge of its notify mask.
  initial begin
    logic [1:0] prev;
    exp_t e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!rst && o_notify2 != 2'b00 && prev == 2'b00) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected got x=%0h mask=%0b want none", o_x2, o_notify2);
        end else begin
          e = exp_q.pop_front();
          chk("sb_mask", 32'(o_notify2), 32'(e.mask));
          chk("sb_mode", 32'(o_mode2), 32'(e.md));
          chk("sb_x", 32'(o_x2), 32'(e.x));
          chk("sb_y", 32'(o_y2), 32'(e.y));
        end
      end
      prev = rst ? 2'b00 : o_notify2;
    end
  end

  task automatic send2(input logic md, input logic [7:0] x, input logic y,
                       input logic [1:0] mask, input logic [7:0] ex, input logic ey);
    int n;
    exp_t e;
    n = 0;
    while (!m_notify2 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("send2_ready", 32'(m_notify2), 32'd1);
    m_mode2 = md; m_x2 = x; m_y2 = y; m_sync2 = 1'b1;
    e.mask = mask; e.md = md; e.x = ex; e.y = ey;
    exp_q.push_back(e);
    @(posedge clk); #1;
    acc_cyc = cyc;
    m_sync2 = 1'b0;
  endtask

  task automatic send4(input logic md, input logic [7:0] x, input logic y);
    int n;
    n = 0;
    while (!m_notify4 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("send4_ready", 32'(m_notify4), 32'd1);
    m_mode4 = md; m_x4 = x; m_y4 = y; m_sync4 = 1'b1;
    @(posedge clk); #1;
    m_sync4 = 1'b0;
  endtask

  initial begin
    int prev_acc;
    logic [3:0] sync_sched [1:6];
    logic [3:0] notify_exp [1:6];

    tbl[0] = '{1'b0, 8'h05, 1'b0, 2'b01, 8'h05, 1'b0};
    tbl[1] = '{1'b1, 8'h07, 1'b0, 2'b10, 8'h08, 1'b0};
    tbl[2] = '{1'b0, 8'h09, 1'b1, 2'b01, 8'h09, 1'b0};
    tbl[3] = '{1'b1, 8'hFF, 1'b0, 2'b10, 8'h00, 1'b0};
    tbl[4] = '{1'b1, 8'h03, 1'b1, 2'b11, 8'h04, 1'b1};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 2'b01, 8'h00, 1'b1};
    tbl[6] = '{1'b1, 8'h0A, 1'b0, 2'b10, 8'h0B, 1'b0};

    sync_sched[1] = 4'b0100; notify_exp[1] = 4'b1011;
    sync_sched[2] = 4'b0000; notify_exp[2] = 4'b1011;
    sync_sched[3] = 4'b1001; notify_exp[3] = 4'b0010;
    sync_sched[4] = 4'b0101; notify_exp[4] = 4'b0010;
    sync_sched[5] = 4'b0000; notify_exp[5] = 4'b0010;
    sync_sched[6] = 4'b0010; notify_exp[6] = 4'b0000;

    m_mode2 = 0; m_x2 = 0; m_y2 = 0; m_sync2 = 0; o_sync2 = 2'b11;
    m_mode4 = 0; m_x4 = 0; m_y4 = 0; m_sync4 = 0; o_sync4 = 4'b1111;
    acc_cyc = 0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("rst_m_notify", 32'(m_notify2), 32'd1);
      chk("rst_b_notify", 32'(o_notify2), 32'd0);
      chk("rst_color", 32'(color2), 32'd0);
    end
    chk("rst4_b_notify", 32'(o_notify4), 32'd0);
    chk("rst4_m_notify", 32'(m_notify4), 32'd1);

    prev_acc = 0;
    for (int i = 0; i < 7; i++) begin
      send2(tbl[i].md, tbl[i].x, tbl[i].y, tbl[i].mask, tbl[i].ex, tbl[i].ey);
      if (i == 1 || i == 2) chk("period", 32'(acc_cyc - prev_acc), 32'd2);
      prev_acc = acc_cyc;
      if (i == 2) begin
        @(posedge clk); #1;
        chk("color_after3", 32'(color2), 32'd0);
      end
    end

    // Backpressure: ch0 held off, producer keeps pulsing sync.
    @(posedge clk); #1;
    o_sync2 = 2'b10;
    send2(1'b0, 8'h21, 1'b0, 2'b01, 8'h21, 1'b0);
    for (int k = 0; k < 20; k++) begin
      m_mode2 = 1'b1; m_x2 = 8'h55; m_y2 = 1'b1; m_sync2 = k[0];
      @(posedge clk); #1;
      chk("bp_x", 32'(o_x2), 32'h21);
      chk("bp_notify", 32'(o_notify2), 32'b01);
      chk("bp_m_notify", 32'(m_notify2), 32'd0);
    end
    m_sync2 = 1'b0;
    o_sync2 = 2'b11;
    send2(1'b1, 8'h30, 1'b0, 2'b10, 8'h31, 1'b1);

    // Reset in SEC_B with the pointer at 1.
    send2(1'b0, 8'h41, 1'b0, 2'b01, 8'h41, 1'b0);
    @(posedge clk); #1;
    o_sync2 = 2'b00;
    send2(1'b0, 8'h42, 1'b0, 2'b10, 8'h42, 1'b0);
    @(posedge clk); #1;
    chk("pre_rst_notify", 32'(o_notify2), 32'b10);
    #1 rst = 1'b1;
    #1;
    chk("arst_m_notify", 32'(m_notify2), 32'd1);
    chk("arst_b_notify", 32'(o_notify2), 32'd0);
    chk("arst_color", 32'(color2), 32'd0);
    chk("arst_x", 32'(o_x2), 32'd0);
    #1 rst = 1'b0;
    o_sync2 = 2'b11;
    send2(1'b0, 8'h43, 1'b0, 2'b01, 8'h43, 1'b0);
    @(posedge clk); #1;

    // NCH=4: one unicast to move the pointer, then staggered broadcast.
    o_sync4 = 4'b1111;
    send4(1'b0, 8'h01, 1'b0);
    chk("u4_notify", 32'(o_notify4), 32'b0001);
    chk("u4_x", 32'(o_x4), 32'h01);
    @(posedge clk); #1;
    chk("u4_done", 32'(m_notify4), 32'd1);
    chk("u4_color", 32'(color4), 32'd1);
    o_sync4 = 4'b0000;
    send4(1'b1, 8'h10, 1'b1);
    chk("bc_notify0", 32'(o_notify4), 32'b1111);
    chk("bc_x", 32'(o_x4), 32'h11);
    chk("bc_y", 32'(o_y4), 32'd1);
    for (int k = 1; k <= 6; k++) begin
      o_sync4 = sync_sched[k];
      @(posedge clk); #1;
      chk("bc_notify", 32'(o_notify4), 32'(notify_exp[k]));
      chk("bc_m_notify", 32'(m_notify4), (k == 6) ? 32'd1 : 32'd0);
      chk("bc_x_hold", 32'(o_x4), 32'h11);
    end
    o_sync4 = 4'b0000;
    chk("bc_color", 32'(color4), 32'd2);
    send4(1'b0, 8'h02, 1'b0);
    chk("bc_ptr_kept", 32'(o_notify4), 32'b0010);
    chk("red_flip4", 32'(o_y4), 32'd1);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
